// File: rtl/ce_strobe_pkg.sv
// ---------------------------------------------------------------------------
// ce_strobe_pkg
//
// Shared definitions for the clock-enable strobe generator:
//   - state_e        : two-state controller encoding (IDLE / RUN)
//   - DEF_WIDTH      : default divisor / counter width in bits
//   - DEF_INIT_DIV   : default divisor loaded at reset
//   - run_mode_e     : meaning of the MODE input
// ---------------------------------------------------------------------------
package ce_strobe_pkg;

    // Controller state. The encoding is fixed so BUSY is simply the state bit.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Run mode as sampled from MODE when leaving IDLE.
    typedef enum logic {
        MODE_FREE_RUN = 1'b0,
        MODE_ONE_SHOT = 1'b1
    } run_mode_e;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_INIT_DIV = 325;

endpackage : ce_strobe_pkg

// File: rtl/ce_down_counter.sv
// ---------------------------------------------------------------------------
// ce_down_counter
//
// Loadable WIDTH-bit down-counter with a zero flag.
//
// Ports:
//   clk_i       in   1      rising-edge clock
//   rst_i       in   1      asynchronous active-high reset (counter <= RST_VAL)
//   load_i      in   1      load load_val_i on the next edge (wins over dec_i)
//   load_val_i  in   WIDTH  value to load
//   dec_i       in   1      decrement on the next edge
//   cnt_o       out  WIDTH  current count (registered)
//   zero_o      out  1      count is zero
//
// A decrement request at zero is ignored, so the counter only ever wraps by
// an explicit load and never underflows.
// ---------------------------------------------------------------------------
module ce_down_counter
    import ce_strobe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_INIT_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             zero;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = zero;

endmodule : ce_down_counter

// File: rtl/ce_strobe_gen.sv
// ---------------------------------------------------------------------------
// ce_strobe_gen
//
// Programmable clock-enable strobe generator. Divides CLK by (active_div + 1)
// and emits a registered single-cycle CE_OUT pulse per period, in free-run
// or one-shot mode. Divisor writes while running are parked in a shadow
// register and take effect at the next reload, so a period is never cut
// short or stretched.
//
// Ports:
//   CLK     in   1      clock, all state changes on the rising edge
//   RST     in   1      asynchronous active-high reset
//   EN      in   1      free-run enable (level); ignored in one-shot
//   MODE    in   1      0 = free-run, 1 = one-shot; sampled only in IDLE
//   START   in   1      one-shot trigger pulse; ignored unless IDLE and MODE=1
//   DIV_WE  in   1      divisor write strobe
//   DIV_IN  in   WIDTH  divisor value to write
//   CE_OUT  out  1      registered strobe, one cycle high per period
//   BUSY    out  1      high while in RUN (registered, equals the state bit)
//   CNT     out  WIDTH  current down-counter value
//
// Handshake: there is no valid/ready pairing here. DIV_WE and START are
// single-cycle strobes sampled on every rising edge; the block always
// accepts them (a START outside IDLE/one-shot is simply dropped).
// ---------------------------------------------------------------------------
module ce_strobe_gen
    import ce_strobe_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT_DIV = WIDTH'(DEF_INIT_DIV)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             MODE,
    input  logic             START,
    input  logic             DIV_WE,
    input  logic [WIDTH-1:0] DIV_IN,
    output logic             CE_OUT,
    output logic             BUSY,
    output logic [WIDTH-1:0] CNT
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,  state_d;
    run_mode_e        mode_q,   mode_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pend_q,   pend_d;
    logic             ce_q,     ce_d;

    // Counter control
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_zero;

    // Shadow view that already includes a write landing on this edge, so a
    // write coinciding with a reload or stop is used immediately.
    logic             eff_pend;
    logic [WIDTH-1:0] eff_shadow;
    logic             start_cond;

    assign eff_pend   = pend_q | DIV_WE;
    assign eff_shadow = DIV_WE ? DIV_IN : shadow_q;
    assign start_cond = (MODE == 1'b0) ? EN : START;

    ce_down_counter #(
        .WIDTH   (WIDTH),
        .RST_VAL (INIT_DIV)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pend_d       = pend_q;
        ce_d         = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = active_q;
        cnt_dec      = 1'b0;

        if (DIV_WE) begin
            shadow_d = DIV_IN;
        end

        unique case (state_q)
            IDLE: begin
                // Nothing is counting, so a write applies straight away.
                if (DIV_WE) begin
                    active_d = DIV_IN;
                    pend_d   = 1'b0;
                end
                if (start_cond) begin
                    state_d      = RUN;
                    mode_d       = run_mode_e'(MODE);
                    cnt_load     = 1'b1;
                    cnt_load_val = DIV_WE ? DIV_IN : active_q;
                end
            end

            RUN: begin
                if (mode_q == MODE_FREE_RUN && !EN) begin
                    // Stop wins over a terminal count on the same edge:
                    // no strobe, and any parked divisor becomes active.
                    state_d  = IDLE;
                    cnt_load = 1'b1;
                    pend_d   = 1'b0;
                    if (eff_pend) begin
                        active_d     = eff_shadow;
                        cnt_load_val = eff_shadow;
                    end else begin
                        cnt_load_val = active_q;
                    end
                end else if (cnt_zero) begin
                    // Terminal count: strobe and reload. The new divisor
                    // only enters here, so the outgoing period is complete.
                    ce_d     = 1'b1;
                    cnt_load = 1'b1;
                    pend_d   = 1'b0;
                    if (eff_pend) begin
                        active_d     = eff_shadow;
                        cnt_load_val = eff_shadow;
                    end else begin
                        cnt_load_val = active_q;
                    end
                    if (mode_q == MODE_ONE_SHOT) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                    if (DIV_WE) begin
                        pend_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            mode_q   <= MODE_FREE_RUN;
            shadow_q <= INIT_DIV;
            active_q <= INIT_DIV;
            pend_q   <= 1'b0;
            ce_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            ce_q     <= ce_d;
        end
    end

    assign CE_OUT = ce_q;
    assign BUSY   = (state_q == RUN);
    assign CNT    = cnt_val;

endmodule : ce_strobe_gen

// File: tb/tb_ce_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_ce_strobe_gen
//
// Directed bench for ce_strobe_gen (WIDTH=16, INIT_DIV=325). Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, so
// each step() call advances exactly one (or n) active edges.
// ---------------------------------------------------------------------------
module tb_ce_strobe_gen;

    localparam int W = 16;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic          MODE;
    logic          START;
    logic          DIV_WE;
    logic [W-1:0]  DIV_IN;
    logic          CE_OUT;
    logic          BUSY;
    logic [W-1:0]  CNT;

    int n_tests;
    int n_fail;

    ce_strobe_gen #(
        .WIDTH    (W),
        .INIT_DIV (16'd325)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .MODE   (MODE),
        .START  (START),
        .DIV_WE (DIV_WE),
        .DIV_IN (DIV_IN),
        .CE_OUT (CE_OUT),
        .BUSY   (BUSY),
        .CNT    (CNT)
    );

    // Clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver: advance n rising edges, land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic ce, input logic busy, input logic [W-1:0] cnt);
        chk({tag, ".ce"},   32'(CE_OUT), 32'(ce));
        chk({tag, ".busy"}, 32'(BUSY),   32'(busy));
        chk({tag, ".cnt"},  32'(CNT),    32'(cnt));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b1;
        EN      = 1'b0;
        MODE    = 1'b0;
        START   = 1'b0;
        DIV_WE  = 1'b0;
        DIV_IN  = '0;

        // ---- reset state ------------------------------------------------
        #2;
        chk_out("reset", 1'b0, 1'b0, 16'd325);
        step(2);
        RST = 1'b0;
        step(1);
        chk_out("post_reset", 1'b0, 1'b0, 16'd325);

        // ---- 1: free-run, DIV=3 -----------------------------------------
        DIV_WE = 1'b1; DIV_IN = 16'd3;
        step(1);
        DIV_WE = 1'b0;
        chk_out("t1_idle_write", 1'b0, 1'b0, 16'd325);
        EN = 1'b1;
        step(1);
        chk_out("t1_start", 1'b0, 1'b1, 16'd3);
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk_out($sformatf("t1_run%0d", i), (i % 4) == 0, 1'b1, 16'(3 - (i % 4)));
        end
        EN = 1'b0;
        step(1);
        chk_out("t1_stop", 1'b0, 1'b0, 16'd3);

        // ---- 2: DIV=0, strobe every cycle -------------------------------
        DIV_WE = 1'b1; DIV_IN = 16'd0;
        step(1);
        DIV_WE = 1'b0;
        EN = 1'b1;
        step(1);
        chk_out("t2_start", 1'b0, 1'b1, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk_out($sformatf("t2_run%0d", i), 1'b1, 1'b1, 16'd0);
        end
        EN = 1'b0;
        step(1);
        chk_out("t2_stop", 1'b0, 1'b0, 16'd0);

        // ---- 3: one-shot, DIV=5, START mid-run dropped -------------------
        MODE = 1'b1;
        DIV_WE = 1'b1; DIV_IN = 16'd5;
        step(1);
        DIV_WE = 1'b0;
        START = 1'b1;
        step(1);
        START = 1'b0;
        chk_out("t3_start", 1'b0, 1'b1, 16'd5);
        step(2);
        chk_out("t3_cnt3", 1'b0, 1'b1, 16'd3);
        START = 1'b1;
        step(1);
        START = 1'b0;
        chk_out("t3_drop_start", 1'b0, 1'b1, 16'd2);
        step(2);
        chk_out("t3_cnt0", 1'b0, 1'b1, 16'd0);
        step(1);
        chk_out("t3_strobe", 1'b1, 1'b0, 16'd5);
        EN = 1'b1;
        step(1);
        chk_out("t3_after", 1'b0, 1'b0, 16'd5);
        step(6);
        chk_out("t3_en_ignored", 1'b0, 1'b0, 16'd5);
        EN = 1'b0;

        // ---- 4: shadow divisor update -----------------------------------
        MODE = 1'b0;
        DIV_WE = 1'b1; DIV_IN = 16'd7;
        step(1);
        DIV_WE = 1'b0;
        EN = 1'b1;
        step(1);
        chk_out("t4_start", 1'b0, 1'b1, 16'd7);
        step(3);
        chk_out("t4_cnt4", 1'b0, 1'b1, 16'd4);
        DIV_WE = 1'b1; DIV_IN = 16'd2;
        step(1);
        DIV_WE = 1'b0;
        chk_out("t4_pend_write", 1'b0, 1'b1, 16'd3);
        step(3);
        chk_out("t4_old_cnt0", 1'b0, 1'b1, 16'd0);
        step(1);
        chk_out("t4_strobe8", 1'b1, 1'b1, 16'd2);
        step(2);
        chk_out("t4_new_cnt0", 1'b0, 1'b1, 16'd0);
        step(1);
        chk_out("t4_strobe3", 1'b1, 1'b1, 16'd2);
        step(2);
        chk_out("t4_pre_tc", 1'b0, 1'b1, 16'd0);
        DIV_WE = 1'b1; DIV_IN = 16'd4;
        step(1);
        DIV_WE = 1'b0;
        chk_out("t4_tc_write", 1'b1, 1'b1, 16'd4);
        step(4);
        chk_out("t4_cnt0_div4", 1'b0, 1'b1, 16'd0);
        step(1);
        chk_out("t4_strobe5", 1'b1, 1'b1, 16'd4);

        // ---- 5: asynchronous reset mid-period ---------------------------
        step(2);
        chk_out("t5_cnt2", 1'b0, 1'b1, 16'd2);
        #2;
        RST = 1'b1;
        #1;
        chk_out("t5_async", 1'b0, 1'b0, 16'd325);
        step(2);
        chk_out("t5_held", 1'b0, 1'b0, 16'd325);
        RST = 1'b0;
        step(1);
        chk_out("t5_first_edge", 1'b0, 1'b1, 16'd325);
        EN = 1'b0;
        step(1);
        chk_out("t5_stop", 1'b0, 1'b0, 16'd325);

        // ---- 6: idle write of 10, then free-run -------------------------
        DIV_WE = 1'b1; DIV_IN = 16'd10;
        step(1);
        DIV_WE = 1'b0;
        EN = 1'b1;
        step(1);
        chk_out("t6_start", 1'b0, 1'b1, 16'd10);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk($sformatf("t6_wait%0d.ce", i), 32'(CE_OUT), 32'd0);
        end
        chk("t6_cnt0", 32'(CNT), 32'd0);
        step(1);
        chk_out("t6_strobe11", 1'b1, 1'b1, 16'd10);
        EN = 1'b0;
        step(1);
        chk_out("t6_stop", 1'b0, 1'b0, 16'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ce_strobe_gen

// File: doc/ce_strobe_gen.md
# ce_strobe_gen

Programmable clock-enable strobe generator that produces the single-cycle `CE` pulses driving downstream enable-gated flip-flops, such as the dual-edge register stage and the kcpsm3 UART `en_16_x_baud` input. The block divides `CLK` by a run-time-loadable divisor. It supports free-running and one-shot modes, and divisor updates take effect glitch-free through a shadow register. All outputs are registered, so the strobe can feed flop `CE` pins directly with a full cycle of setup.

## Interface

Parameters:
- `WIDTH`, 16: divisor/counter width in bits.
- `INIT_DIV`, 16'd325: divisor value held after reset.

Ports:
- `CLK` in, 1: the only clock; all state changes on its rising edge.
- `RST` in, 1: reset, asynchronous and active-high.
- `EN` in, 1: free-run enable, level-sensitive.
- `MODE` in, 1: 0 = free-run, 1 = one-shot. Sampled only in IDLE.
- `START` in, 1: one-shot trigger, single-cycle pulse. Ignored when `MODE`=0 or when not in IDLE.
- `DIV_WE` in, 1: divisor write strobe.
- `DIV_IN` in, WIDTH: divisor value to write.
- `CE_OUT` out, 1: registered strobe, high for exactly one cycle per period.
- `BUSY` out, 1: high while in RUN.
- `CNT` out, WIDTH: current down-counter value, for readback.

## Operation

- Two states: IDLE and RUN.
- Registers:
  - `shadow_div`: last value written via `DIV_WE`.
  - `active_div`: divisor in use.
  - `CNT`.
  - `pend`: flag meaning `shadow_div` has not yet been applied.
- Period is `active_div`+1 cycles. `active_div`=0 gives `CE_OUT` high on every cycle in RUN.
- `DIV_WE`:
  - Any state: `shadow_div`←`DIV_IN`.
  - In RUN: `pend`←1.
  - In IDLE: `active_div`←`DIV_IN` immediately and `pend`←0.
- IDLE→RUN:
  - Free-run: `MODE`=0 and `EN`=1.
  - One-shot: `MODE`=1 and `START`=1.
  - On that edge, `CNT`←`active_div` (or `DIV_IN` if `DIV_WE` is asserted on the same edge).
- In RUN, on each edge:
  - If `CNT`≠0: `CNT`←`CNT`−1 and `CE_OUT`←0.
  - If `CNT`=0: `CE_OUT`←1 and reload. The reload uses `shadow_div` if `pend`=1 (also copying it to `active_div` and clearing `pend`), otherwise `active_div`.
- RUN→IDLE:
  - Free-run: on the first edge where `EN`=0. `CE_OUT`←0 and `CNT`←`active_div`. A pending shadow is applied at this point.
  - One-shot: on the edge that asserts `CE_OUT`. Exactly one strobe per `START`.
- `EN` in one-shot mode and `START` in free-run mode have no effect. A `START` arriving while in RUN is dropped, not queued.
- Simultaneous `DIV_WE` and terminal count (`CNT`=0): the reload uses the new `DIV_IN` value, and `pend` ends at 0.
- `CNT` wraps only by reload and never underflows.

## Timing

- Reset values:
  - State = IDLE.
  - `CE_OUT`=0, `BUSY`=0.
  - `CNT`=`INIT_DIV`.
  - `active_div`=`shadow_div`=`INIT_DIV`.
  - `pend`=0.
- `RST` mid-period aborts immediately and asynchronously. No strobe is emitted while `RST` is high, or on the first edge after release.
- Latency:
  - Start condition sampled at edge k → first `CE_OUT` high after edge k+D+1, where D = `active_div` at start.
  - In free-run, subsequent strobes follow every D+1 edges.
- `BUSY` rises after the start edge and falls after the stop edge.
- A divisor change in RUN never produces a short or long period. The old period completes, then the new one begins.

## Structure

- Shared package `ce_strobe_pkg`: state enum (IDLE=1'b0, RUN=1'b1), `WIDTH` default, `INIT_DIV` default.
- One natural sub-module, `ce_down_counter`: a loadable WIDTH-bit down-counter with a zero flag and load/decrement enables. The FSM and shadow logic remain in the top level.

## Test plan

1. Reset then `EN`=1, `MODE`=0, `DIV`=3 → `CE_OUT` pulses after edges 4, 8, 12. `BUSY`=1 throughout. `CNT` sequence 3,2,1,0,3.
2. `DIV`=0, free-run → `CE_OUT` high on every cycle after the start edge. Drop `EN` → `CE_OUT` is 0 the next cycle.
3. `MODE`=1, `DIV`=5, `START` pulse → single `CE_OUT` after edge 6, then `BUSY`=0. A second `START` mid-run → no extra strobe.
4. Free-run with `DIV`=7. Write `DIV_IN`=2 at `CNT`=4 → current period completes at 8 cycles, then 3-cycle periods. Write coinciding with `CNT`=0 → new value used on that very reload.
5. Assert `RST` asynchronously mid-period at `CNT`=2 → `CE_OUT`/`BUSY` go to 0 and `CNT`=325 immediately, without waiting for a clock edge. No strobe on the first edge after release.
6. `DIV_WE` in IDLE with 10, then `EN`=1 → first strobe 11 cycles after the start edge.
